// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   y;

    // Controller side: issues requests, watches status and product.
    modport master (
        output start, is_signed, a, b,
        input  busy, done, y
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, a, b,
        output busy, done, y
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// Signed operands are reduced to magnitudes on acceptance, multiplied
// unsigned over WIDTH steps, and the sign is applied in a final RUN cycle
// (cnt == WIDTH) that also loads y, so y and done appear together.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      y_q, y_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1),
    // which still fits unsigned in WIDTH bits.
    assign a_neg = bus.is_signed & bus.a[WIDTH-1];
    assign b_neg = bus.is_signed & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.y    = y_q;

    // State and datapath registers; reset clears everything, aborting any op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            y_q      <= y_d;
        end
    end

    // Next-state and shift-add step; start is only honoured in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                    y_d     = neg_q ? -acc_q : acc_q;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
